// File: rtl/serial_audio_pkg.sv
// Shared definitions for the serial audio encoder/decoder pair.
package serial_audio_pkg;

  // Default recovered / transmitted sample width.
  localparam int DEFAULT_DATA_W = 16;

  // Format flag meanings for is_i2s.
  localparam logic FMT_LJ  = 1'b0;  // MSB coincident with lrclk edge
  localparam logic FMT_I2S = 1'b1;  // MSB one sclk after lrclk edge

  // Link synchronisation state.
  typedef enum logic {
    UNSYNC = 1'b0,
    RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/serial_audio_slot_detector.sv
// Input registers, I2S alignment delay and slot-boundary detection.
// ws changes in the same cycle that the new slot's MSB sits in sdat_p0,
// independent of format, so the capture logic never needs to know it.
module serial_audio_slot_detector
  import serial_audio_pkg::*;
(
  input  logic sclk,
  input  logic reset,
  input  logic is_i2s,
  input  logic lrclk,
  input  logic sdat,
  output logic ws,
  output logic boundary,
  output logic sdat_p0
);

  logic lrclk_p0;
  logic lrclk_p1;
  logic ws_prev;

  // Stage p0: register the pins; p1: extra word-select delay for I2S.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      lrclk_p0 <= 1'b0;
      sdat_p0  <= 1'b0;
      lrclk_p1 <= 1'b0;
      ws_prev  <= 1'b0;
    end else begin
      lrclk_p0 <= lrclk;
      sdat_p0  <= sdat;
      lrclk_p1 <= lrclk_p0;
      ws_prev  <= ws;
    end
  end

  assign ws       = (is_i2s == FMT_I2S) ? lrclk_p1 : lrclk_p0;
  assign boundary = (ws != ws_prev);

endmodule

// File: rtl/serial_audio_decoder.sv
// Deserializes an I2S / left-justified stereo stream into tagged samples
// presented on a single-entry valid/ready output register.
module serial_audio_decoder
  import serial_audio_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_W
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  is_i2s,
  input  logic                  lrclk_polarity,
  input  logic                  lrclk,
  input  logic                  sdat,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_is_left,
  output logic [data_width-1:0] o_data,
  output logic                  is_overrun
);

  localparam int CNT_W = $clog2(data_width + 1);

  logic                  ws;
  logic                  boundary;
  logic                  sdat_p0;
  state_t                state;
  state_t                state_next;
  logic                  publish;
  logic [data_width-1:0] word;
  logic [CNT_W-1:0]      count;
  logic                  slot_left;

  serial_audio_slot_detector u_slot_detector (
    .sclk     (sclk),
    .reset    (reset),
    .is_i2s   (is_i2s),
    .lrclk    (lrclk),
    .sdat     (sdat),
    .ws       (ws),
    .boundary (boundary),
    .sdat_p0  (sdat_p0)
  );

  // Sync state register.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) state <= UNSYNC;
    else       state <= state_next;
  end

  // First boundary only synchronises; later boundaries publish the finished slot.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    case (state)
      UNSYNC: if (boundary) state_next = RUN;
      RUN:    publish = boundary;
      default: state_next = UNSYNC;
    endcase
  end

  // Stage p1: capture shifter; MSB loaded at boundary, later bits fill downward
  // until the counter saturates (longer slots lose LSBs, shorter leave zeros).
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      word      <= '0;
      count     <= '0;
      slot_left <= 1'b0;
    end else if (boundary) begin
      word      <= {sdat_p0, {(data_width-1){1'b0}}};
      count     <= CNT_W'(1);
      slot_left <= (ws == lrclk_polarity);
    end else if (state == RUN && count < CNT_W'(data_width)) begin
      word  <= word | ({{(data_width-1){1'b0}}, sdat_p0} << (CNT_W'(data_width - 1) - count));
      count <= count + CNT_W'(1);
    end
  end

  // Stage p2: single-entry output register; a word arriving while the held
  // one is still unaccepted is dropped and flagged.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_is_left  <= 1'b0;
      o_data     <= '0;
      is_overrun <= 1'b0;
    end else begin
      is_overrun <= 1'b0;
      if (publish) begin
        if (!o_valid || o_ready) begin
          o_valid   <= 1'b1;
          o_data    <= word;
          o_is_left <= slot_left;
        end else begin
          is_overrun <= 1'b1;
        end
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_audio_decoder.sv
// Directed bench for serial_audio_decoder: bit streams built slot by slot,
// accepted samples collected by a monitor and compared to hand-computed values.
module tb_serial_audio_decoder;

  localparam int DW = 16;

  logic          sclk = 1'b0;
  logic          reset;
  logic          is_i2s;
  logic          lrclk_polarity;
  logic          lrclk;
  logic          sdat;
  logic          o_valid;
  logic          o_ready;
  logic          o_is_left;
  logic [DW-1:0] o_data;
  logic          is_overrun;

  serial_audio_decoder #(.data_width(DW)) dut (
    .sclk           (sclk),
    .reset          (reset),
    .is_i2s         (is_i2s),
    .lrclk_polarity (lrclk_polarity),
    .lrclk          (lrclk),
    .sdat           (sdat),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .o_is_left      (o_is_left),
    .o_data         (o_data),
    .is_overrun     (is_overrun)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: record every accepted sample and every overrun cycle.
  logic [31:0] rec_data[$];
  logic        rec_left[$];
  int          rec_cyc[$];
  int          ovr_cnt = 0;

  initial begin
    forever begin
      @(negedge sclk);
      #1;
      if (o_valid === 1'b1 && o_ready === 1'b1) begin
        rec_data.push_back(32'(o_data));
        rec_left.push_back(o_is_left);
        rec_cyc.push_back(cyc);
      end
      if (is_overrun === 1'b1) ovr_cnt++;
    end
  end

  function automatic logic [31:0] get_d(input int i);
    return (i < rec_data.size()) ? rec_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] get_l(input int i);
    return (i < rec_left.size()) ? {31'b0, rec_left[i]} : 32'hFF;
  endfunction

  function automatic int get_c(input int i);
    return (i < rec_cyc.size()) ? rec_cyc[i] : -1;
  endfunction

  // Stream builder: one entry per sclk bit.
  logic q_lr[$];
  logic q_dat[$];
  int   start_cyc[$];

  task automatic add_slot(input logic lr, input logic [31:0] val, input int len);
    for (int i = 0; i < len; i++) begin
      q_lr.push_back(lr);
      q_dat.push_back(val[len-1-i]);
    end
  endtask

  // Drive the queued stream on falling edges; in I2S lrclk leads data by one bit.
  task automatic play();
    for (int n = 0; n < q_lr.size(); n++) begin
      @(negedge sclk);
      lrclk = (is_i2s && (n + 1 < q_lr.size())) ? q_lr[n+1] : q_lr[n];
      sdat  = q_dat[n];
      if (n == 0 || q_lr[n] != q_lr[n-1]) start_cyc.push_back(cyc);
    end
    q_lr.delete();
    q_dat.delete();
    repeat (3) @(negedge sclk);
  endtask

  task automatic clear_rec();
    rec_data.delete();
    rec_left.delete();
    rec_cyc.delete();
    start_cyc.delete();
    ovr_cnt = 0;
  endtask

  task automatic do_reset(input logic i2s, input logic pol);
    @(negedge sclk);
    reset          = 1'b1;
    is_i2s         = i2s;
    lrclk_polarity = pol;
    lrclk          = 1'b0;
    sdat           = 1'b0;
    repeat (2) @(negedge sclk);
    reset = 1'b0;
    clear_rec();
  endtask

  initial begin
    reset          = 1'b1;
    is_i2s         = 1'b0;
    lrclk_polarity = 1'b0;
    lrclk          = 1'b0;
    sdat           = 1'b0;
    o_ready        = 1'b1;
    repeat (2) @(negedge sclk);
    #1;
    chk("rst_valid",   32'(o_valid),    32'd0);
    chk("rst_left",    32'(o_is_left),  32'd0);
    chk("rst_data",    32'(o_data),     32'd0);
    chk("rst_overrun", 32'(is_overrun), 32'd0);

    // LJ stream, polarity 0: leading partial L is ignored, first boundary at R.
    do_reset(1'b0, 1'b0);
    o_ready = 1'b1;
    add_slot(1'b0, 32'hAAAB, 16);
    add_slot(1'b1, 32'hAAAA, 16);
    add_slot(1'b0, 32'hAAAB, 16);
    add_slot(1'b1, 32'hAAAA, 16);
    add_slot(1'b0, 32'h0, 4);
    play();
    chk("lj_count",  32'(rec_data.size()), 32'd3);
    chk("lj_d0",     get_d(0), 32'hAAAA);
    chk("lj_l0",     get_l(0), 32'd0);
    chk("lj_d1",     get_d(1), 32'hAAAB);
    chk("lj_l1",     get_l(1), 32'd1);
    chk("lj_d2",     get_d(2), 32'hAAAA);
    chk("lj_l2",     get_l(2), 32'd0);
    chk("lj_ovr",    32'(ovr_cnt), 32'd0);

    // I2S, polarity 0: sync slot, then L 8001 and R 7FFE.
    do_reset(1'b1, 1'b0);
    add_slot(1'b0, 32'h0, 3);
    add_slot(1'b1, 32'h0F0F, 16);
    add_slot(1'b0, 32'h8001, 16);
    add_slot(1'b1, 32'h7FFE, 16);
    add_slot(1'b0, 32'h0, 4);
    play();
    chk("i2s_count", 32'(rec_data.size()), 32'd3);
    chk("i2s_d0",    get_d(0), 32'h0F0F);
    chk("i2s_l0",    get_l(0), 32'd0);
    chk("i2s_d1",    get_d(1), 32'h8001);
    chk("i2s_l1",    get_l(1), 32'd1);
    chk("i2s_d2",    get_d(2), 32'h7FFE);
    chk("i2s_l2",    get_l(2), 32'd0);
    chk("i2s_lat1",  32'(get_c(1)), 32'(start_cyc[3] + 2));
    chk("i2s_lat2",  32'(get_c(2)), 32'(start_cyc[4] + 2));

    // Slot length mismatch: short slot zero-fills, long slot truncates.
    do_reset(1'b0, 1'b0);
    add_slot(1'b0, 32'h0, 3);
    add_slot(1'b1, 32'hABC, 12);
    add_slot(1'b0, 32'h123456, 24);
    add_slot(1'b1, 32'h0, 4);
    play();
    chk("len_count", 32'(rec_data.size()), 32'd2);
    chk("len_short", get_d(0), 32'hABC0);
    chk("len_long",  get_d(1), 32'h1234);
    chk("len_l1",    get_l(1), 32'd1);

    // Polarity 1: lrclk-high slot is the left channel.
    do_reset(1'b0, 1'b1);
    add_slot(1'b0, 32'h0, 3);
    add_slot(1'b1, 32'h5555, 16);
    add_slot(1'b0, 32'h0, 4);
    play();
    chk("pol_count", 32'(rec_data.size()), 32'd1);
    chk("pol_d0",    get_d(0), 32'h5555);
    chk("pol_l0",    get_l(0), 32'd1);

    // Backpressure across two boundaries.
    do_reset(1'b0, 1'b0);
    o_ready = 1'b0;
    add_slot(1'b0, 32'h0, 3);
    add_slot(1'b1, 32'h1111, 16);
    add_slot(1'b0, 32'h2222, 16);
    add_slot(1'b1, 32'h0, 6);
    play();
    #1;
    chk("bp_valid",  32'(o_valid),   32'd1);
    chk("bp_held",   32'(o_data),    32'h1111);
    chk("bp_left",   32'(o_is_left), 32'd0);
    chk("bp_ovr",    32'(ovr_cnt),   32'd1);
    chk("bp_none",   32'(rec_data.size()), 32'd0);
    @(negedge sclk);
    o_ready = 1'b1;
    repeat (4) @(negedge sclk);
    #1;
    chk("bp_count",  32'(rec_data.size()), 32'd1);
    chk("bp_d0",     get_d(0), 32'h1111);
    chk("bp_ovr2",   32'(ovr_cnt), 32'd1);
    chk("bp_drain",  32'(o_valid), 32'd0);

    // Reset mid-slot while a sample is held.
    do_reset(1'b0, 1'b0);
    o_ready = 1'b0;
    add_slot(1'b0, 32'h0, 3);
    add_slot(1'b1, 32'h3333, 16);
    add_slot(1'b0, 32'hFFFF, 6);
    play();
    #1;
    chk("mr_pre_valid", 32'(o_valid), 32'd1);
    @(negedge sclk);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_valid",   32'(o_valid),    32'd0);
    chk("mr_data",    32'(o_data),     32'd0);
    chk("mr_left",    32'(o_is_left),  32'd0);
    chk("mr_overrun", 32'(is_overrun), 32'd0);
    lrclk = 1'b0;
    sdat  = 1'b0;
    repeat (2) @(negedge sclk);
    reset   = 1'b0;
    o_ready = 1'b1;
    clear_rec();
    add_slot(1'b0, 32'h0, 3);
    add_slot(1'b1, 32'h4444, 16);
    add_slot(1'b0, 32'h5555, 16);
    add_slot(1'b1, 32'h0, 4);
    play();
    chk("mr_count", 32'(rec_data.size()), 32'd2);
    chk("mr_d0",    get_d(0), 32'h4444);
    chk("mr_l0",    get_l(0), 32'd0);
    chk("mr_d1",    get_d(1), 32'h5555);
    chk("mr_l1",    get_l(1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
